// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - circular instruction queue with MIPS field decode of the head entry
module instr_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_data,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [5:0]      opcode,
   output logic [4:0]      rs,
   output logic [4:0]      rt,
   output logic [4:0]      rd,
   output logic [4:0]      shamt,
   output logic [5:0]      funct,
   output logic [15:0]     imm16,
   output logic [31:0]     imm_sext,
   output logic [25:0]     target,
   output logic [CW-1:0]   count,
   output logic            full,
   output logic            empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]   wp_q, wp_d;
   logic [AW-1:0]   rp_q, rp_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     word_q [DEPTH];
   logic [PC_W-1:0] pc_q   [DEPTH];

   logic            push;
   logic            pop;
   logic [31:0]     head_word;
   logic [PC_W-1:0] head_pc;

   // Status comes from registered state only; a same-cycle pop never opens a slot.
   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign count     = count_q;

   // Flush wins over both handshakes, so the offered word is dropped.
   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   // Next-state pointers and occupancy.
   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end else begin
         if (push) wp_d = wp_q + AW'(1);
         if (pop)  rp_d = rp_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers; reset empties the queue immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are left untouched by reset since empty masks them.
   always_ff @(posedge clk) begin
      if (push) begin
         word_q[wp_q] <= in_data;
         pc_q[wp_q]   <= in_pc;
      end
   end

   // Head entry, zeroed when empty so no stale instruction reaches the decoder.
   always_comb begin
      head_word = '0;
      head_pc   = '0;
      if (!empty) begin
         head_word = word_q[rp_q];
         head_pc   = pc_q[rp_q];
      end
   end

   assign out_pc   = head_pc;
   assign opcode   = head_word[31:26];
   assign rs       = head_word[25:21];
   assign rt       = head_word[20:16];
   assign rd       = head_word[15:11];
   assign shamt    = head_word[10:6];
   assign funct    = head_word[5:0];
   assign imm16    = head_word[15:0];
   assign imm_sext = {{16{head_word[15]}}, head_word[15:0]};
   assign target   = head_word[25:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic [31:0] imm_sext;
   logic [25:0] target;
   logic [2:0]  count;
   logic        full;
   logic        empty;

   int n_checks = 0;
   int n_pass   = 0;

   instr_fetch_queue dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .imm16(imm16), .imm_sext(imm_sext), .target(target),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic push_one(input logic [31:0] w, input logic [31:0] p);
      in_valid = 1'b1; in_data = w; in_pc = p; out_ready = 1'b0;
      tick();
      idle();
   endtask

   logic [31:0] wexp [11];
   logic [31:0] pexp [11];

   initial begin
      int sent, recvd, maxc, cyc;
      reset = 1'b1; idle(); in_data = '0; in_pc = '0;
      #12;
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_in_ready", in_ready, 1);
      reset = 1'b0;
      tick();

      // asynchronous reset with two entries loaded
      push_one(32'h8D09FFFC, 32'h100);
      push_one(32'h012A5820, 32'h104);
      check("pre_rst_count", count, 2);
      #2 reset = 1'b1;
      #1;
      check("arst_count", count, 0);
      check("arst_out_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_opcode", opcode, 0);
      check("arst_imm_sext", imm_sext, 0);
      #1 reset = 1'b0;
      tick();

      // decode of lw
      push_one(32'h8D09FFFC, 32'h00400010);
      check("lw_out_valid", out_valid, 1);
      check("lw_opcode", opcode, 6'h23);
      check("lw_rs", rs, 8);
      check("lw_rt", rt, 9);
      check("lw_imm16", imm16, 16'hFFFC);
      check("lw_imm_sext", imm_sext, 32'hFFFFFFFC);
      check("lw_out_pc", out_pc, 32'h00400010);
      out_ready = 1'b1; tick(); idle();
      check("lw_popped_empty", empty, 1);
      check("empty_pc_zero", out_pc, 0);

      // decode of add
      push_one(32'h012A5820, 32'h00400014);
      check("add_opcode", opcode, 0);
      check("add_rs", rs, 9);
      check("add_rt", rt, 10);
      check("add_rd", rd, 11);
      check("add_shamt", shamt, 0);
      check("add_funct", funct, 6'h20);
      check("add_imm_sext", imm_sext, 32'h00005820);
      out_ready = 1'b1; tick(); idle();

      // fill past capacity
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 32'h1000_0000 + i; in_pc = 32'h2000 + 4*i;
         tick();
      end
      idle();
      check("fill_count", count, 4);
      check("fill_full", full, 1);
      check("fill_in_ready", in_ready, 0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain_word%0d", i), {opcode, target}, 32'h1000_0000 + i);
         check($sformatf("drain_pc%0d", i), out_pc, 32'h2000 + 4*i);
         out_ready = 1'b1; tick(); idle();
      end
      check("drain_empty", empty, 1);

      // streaming across pointer wrap with toggling out_ready
      for (int i = 0; i < 11; i++) begin
         wexp[i] = 32'h2000_0000 + 32'h111 * i;
         pexp[i] = 32'h0040_0000 + 4 * i;
      end
      sent = 0; recvd = 0; maxc = 0; cyc = 0;
      while (recvd < 11 && cyc < 200) begin
         in_valid  = (sent < 11);
         in_data   = (sent < 11) ? wexp[sent] : 32'h0;
         in_pc     = (sent < 11) ? pexp[sent] : 32'h0;
         out_ready = cyc[0] | cyc[2];
         if (out_valid && out_ready) begin
            check($sformatf("wrap_word%0d", recvd), {opcode, target}, wexp[recvd]);
            check($sformatf("wrap_pc%0d", recvd), out_pc, pexp[recvd]);
            recvd++;
         end
         if (in_valid && in_ready) sent++;
         tick();
         if (int'(count) > maxc) maxc = int'(count);
         cyc++;
      end
      idle();
      check("wrap_all_received", recvd, 11);
      check("wrap_count_bound", (maxc <= 4), 1);
      check("wrap_end_empty", empty, 1);

      // simultaneous push+pop at count=1
      push_one(32'hAAAA_0001, 32'h10);
      in_valid = 1'b1; in_data = 32'hBBBB_0002; in_pc = 32'h14; out_ready = 1'b1;
      tick(); idle();
      check("pp1_count", count, 1);
      check("pp1_head", {opcode, target}, 32'hBBBB_0002);
      push_one(32'hCCCC_0003, 32'h18);
      push_one(32'hDDDD_0004, 32'h1C);
      check("pp3_pre_count", count, 3);
      in_valid = 1'b1; in_data = 32'hEEEE_0005; in_pc = 32'h20; out_ready = 1'b1;
      tick(); idle();
      check("pp3_count", count, 3);
      check("pp3_head", {opcode, target}, 32'hCCCC_0003);
      push_one(32'hFFFF_0006, 32'h24);
      check("pp4_full", full, 1);
      in_valid = 1'b1; in_data = 32'h1234_0007; in_pc = 32'h28; out_ready = 1'b1;
      tick(); idle();
      check("pp4_count", count, 3);
      check("pp4_head", {opcode, target}, 32'hDDDD_0004);

      // flush overrides push and pop
      flush = 1'b1; in_valid = 1'b1; in_data = 32'h5555_5555; out_ready = 1'b1;
      tick(); idle();
      check("flush_count", count, 0);
      check("flush_empty", empty, 1);
      push_one(32'h08100000, 32'h00400100);
      check("j_target", target, 26'h0100000);
      check("j_opcode", opcode, 6'h02);
      check("j_out_pc", out_pc, 32'h00400100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Parametrised instruction queue: the successor to the single-entry instruction register in the multicycle MIPS core. It buffers up to DEPTH fetched instruction words with their PCs as they arrive from the Avalon read path. It presents the head entry to the control unit already split into MIPS fields, with a valid/ready handshake. A single-cycle flush discards all buffered words on branch/jump redirect or exception.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- PC_W, 32: width of stored PC.
- CW, $clog2(DEPTH)+1: occupancy counter width (derived, not overridable).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries this cycle.
- in_valid  in  1  in_data/in_pc hold a fetched word.
- in_ready  out  1  queue accepts a word this cycle.
- in_data  in  32  instruction word (Avalon readdata).
- in_pc  in  PC_W  address of in_data.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head this cycle.
- out_pc  out  PC_W  PC of head entry.
- opcode  out  6  head[31:26].
- rs  out  5  head[25:21].
- rt  out  5  head[20:16].
- rd  out  5  head[15:11].
- shamt  out  5  head[10:6].
- funct  out  6  head[5:0].
- imm16  out  16  head[15:0].
- imm_sext  out  32  head[15:0] sign-extended.
- target  out  26  head[25:0].
- count  out  CW  entries held, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- Storage: circular buffer of DEPTH entries {word[31:0], pc[PC_W-1:0]}, with write pointer wp, read pointer rp (log2(DEPTH) bits each, natural wrap), and count.
- Push when in_valid && in_ready: write entry at wp, wp+1.
- Pop when out_valid && out_ready: rp+1.
- in_ready = !full. It is computed from registered state only; a pop in the same cycle does not open a slot.
- out_valid = !empty.
- count update: push only +1; pop only −1; both, unchanged; neither, unchanged.
- Push and pop in the same cycle with count==1: legal. The old head leaves and the new word becomes head next cycle.
- Push with in_ready=0: word ignored, no state change. The producer must hold in_valid/in_data until accepted.
- Pop with out_valid=0: ignored.
- Flush: next cycle wp=rp=0, count=0. Flush overrides any push and pop in the same cycle; the word offered that cycle is dropped and in_ready may still read 1.
- Field outputs are decoded combinationally from the entry at rp.
- When empty, all field outputs, imm_sext and out_pc are forced to 0, so the consumer never sees stale data.
- imm_sext = {{16{head[15]}}, head[15:0]}.
- Storage contents are not reset; only pointers and count are.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): wp=rp=0, count=0, which gives empty=1, full=0, out_valid=0, in_ready=1, and all fields/out_pc=0. This takes effect immediately, without waiting for a clock edge.
- Reset mid-operation discards all entries, identical to flush.
- Latency: a word pushed at edge N appears on out_* after edge N. There is no input-to-output combinational bypass.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- At full, one push per cycle requires the pop to have occurred on a prior cycle, so back-to-back full streaming loses one cycle per drain.
- Pointer wrap: after DEPTH pushes, wp returns to 0; ordering is preserved across wrap.
- Outputs full/empty/count/in_ready/out_valid are functions of registered state only.

## Test plan
- Reset/empty: assert reset mid-clock with 2 entries loaded -> same cycle count=0, out_valid=0, in_ready=1, opcode=0, imm_sext=0.
- Decode: push 0x8D09FFFC (lw $9,-4($8)) at pc 0x00400010, then pop -> out_valid=1 the next cycle with opcode=0x23, rs=8, rt=9, imm16=0xFFFC, imm_sext=0xFFFFFFFC, out_pc=0x00400010. Push 0x012A5820 (add) -> rd=11, shamt=0, funct=0x20.
- Fill/full (DEPTH=4): push 5 words with out_ready=0 -> count=4, full=1, in_ready=0, 5th word not stored. Then pop all -> words emerge in push order, and empty=1 after the 4th pop.
- Wrap: push and pop 11 words with out_ready toggling -> output order matches input order, count never exceeds 4, and wp/rp wrap without loss.
- Simultaneous push+pop at count=1 and at count=3 -> count unchanged, head advances; at count=4 with a push offered, the push is refused and count=3.
- Flush priority: count=3 with flush=1, in_valid=1, out_ready=1 in the same cycle -> next cycle count=0, empty=1. A subsequent push of 0x08100000 appears as head with target=0x0100000.
